jt12_op_accum: RTL
==================

# jt12_op_accum

Channel accumulator on the receiving end of the operator output bus. It samples the time-multiplexed 9-bit operator result once per slot over the 24-slot frame. For each of the 6 channels it sums the carrier operators selected by that channel's algorithm, clamps the sum to the 9-bit DAC range, and emits one sample per channel per frame on a serial channel bus. It sits between the operator pipeline and the mixer/DAC stage.

## Interface
Parameters:
- none (6-channel, 24-slot frame fixed)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- clk_en  in  1  slot enable; all state advances only on clk edges with clk_en=1
- zero  in  1  marks that the current op_result belongs to slot 0 (S1, ch0)
- op_result  in  9  signed operator output for the current slot
- alg  in  3  algorithm of the channel owning the current slot, valid with op_result
- mute  in  6  per-channel mute mask, bit n = channel n
- ch_out  out  9  signed clamped channel sample
- ch_idx  out  3  channel index of ch_out, 0..5
- ch_valid  out  1  ch_out/ch_idx updated this slot
- synced  out  1  a zero has been seen since reset

## Operation
- Slot order within the frame, slot s, channel = s mod 6:
  - slots 0-5: S1
  - slots 6-11: S3
  - slots 12-17: S2
  - slots 18-23: S4
- Current slot:
  - equals 0 when zero=1;
  - otherwise equals the internal counter, which advances 0..23 and wraps 23->0.
- On a clk_en edge the counter loads (current slot + 1) mod 24.
- Carrier sets by alg:
  - 0-3: S4 only
  - 4: S2, S4
  - 5, 6: S3, S2, S4
  - 7: S1, S3, S2, S4
- Per-channel 12-bit signed accumulator acc[ch], one per channel.
- S1 slot:
  - acc[ch] = op_result sign-extended if S1 is a carrier, else 0.
  - This always overwrites; no state carries between frames.
- S3 and S2 slots: acc[ch] += op_result if that operator is a carrier, else unchanged.
- S4 slot (always a carrier):
  - sum = acc[ch] + op_result, 12-bit signed, no overflow possible (|sum| ≤ 1024).
  - Clamp to [-256, +255].
  - If mute[ch]=1, output 0 instead.
  - Register to ch_out, with ch_idx=ch and ch_valid=1.
- alg is sampled at every slot. The carrier decision uses the alg present at that slot. A change of alg mid-frame therefore affects only the remaining slots of that frame.
- Resync: zero at a slot where the counter ≠ 0 forces slot 0.
  - Partial sums are discarded naturally by the S1 overwrite.
  - No ch_valid is emitted for the channels that were interrupted.
- Before synced=1, ch_valid stays 0 and accumulators are not updated.
  - The counter free-runs from 0.
- synced sets on the first clk_en edge with zero=1 and stays set until rst.

## Timing
- Reset values: ch_out=0, ch_idx=0, ch_valid=0, synced=0, counter=0, all acc=0.
- Latency: ch_out for channel c is valid after the clk_en edge that samples slot 18+c, i.e. 1 clk_en cycle.
- ch_valid is high for exactly one clk_en-qualified cycle per channel per frame: six pulses per 24 slots, with ch_idx 0..5 in order.
- With clk_en=0, all state holds, including ch_valid. Consumers qualify ch_valid with clk_en.
- If zero and rst are both asserted, rst wins: synced=0 and counter=0.
- rst mid-frame aborts all sums. The first ch_valid after reset follows the S4 slot of the first complete frame after zero.
- mute is sampled at the S4 slot only.

## Test plan
- **Alg 7 sum.** alg=7, op_result=+10 in all slots, zero pulsed at slot 0 → six ch_valid pulses with ch_out=+40, ch_idx 0..5, one clk_en after slots 18..23.
- **Alg 0 and alg 4 carriers.** alg=0, S1/S3/S2=+100, S4=+5 → ch_out=+5. alg=4, S2=+100, S4=+50 → ch_out=+150.
- **Clamp.** alg=7, all ops=+200 → ch_out=+255. All ops=-200 → ch_out=-256. Mixed +255, -256, +255, -256 → -2.
- **Mute.** mute=6'b000100, alg=7, ops=+1 → ch2 ch_out=0 with ch_valid still pulsed; the other channels give +4.
- **Resync.** zero asserted again at slot 10 → counter restarts at 0, no ch_valid for slots 18-23 of the aborted frame, and correct sums in the next frame.
- **clk_en gating and reset.** clk_en toggled 1-in-3 → same ch_out sequence as with clk_en always 1. rst at slot 20 → outputs 0, synced=0, no ch_valid until after the next zero frame's slot 18.

Source files
------------

// File: rtl/jt12_op_accum.sv
// rtl/jt12_op_accum.sv - per-channel carrier accumulator over the 24-slot operator frame
module jt12_op_accum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       zero,
    input  logic [8:0] op_result,
    input  logic [2:0] alg,
    input  logic [5:0] mute,
    output logic [8:0] ch_out,
    output logic [2:0] ch_idx,
    output logic       ch_valid,
    output logic       synced
);

    typedef enum logic [1:0] {
        OP_S1 = 2'd0,
        OP_S3 = 2'd1,
        OP_S2 = 2'd2,
        OP_S4 = 2'd3
    } op_grp_t;

    logic [4:0]         cnt;
    logic [4:0]         cur_slot;
    logic [4:0]         ch_off;
    logic [2:0]         ch;
    op_grp_t            grp;
    logic               carrier;
    logic               active;
    logic signed [11:0] acc [6];
    logic signed [11:0] op_ext;
    logic signed [11:0] sum;
    logic [8:0]         sat;

    // zero overrides the counter so a late sync pulse realigns the frame at once
    assign cur_slot = zero ? 5'd0 : cnt;
    assign active   = synced | zero;
    assign op_ext   = {{3{op_result[8]}}, op_result};
    assign ch       = ch_off[2:0];
    assign sum      = acc[ch] + op_ext;

    always_comb begin
        grp    = OP_S1;
        ch_off = cur_slot;
        if (cur_slot >= 5'd18) begin
            grp    = OP_S4;
            ch_off = cur_slot - 5'd18;
        end else if (cur_slot >= 5'd12) begin
            grp    = OP_S2;
            ch_off = cur_slot - 5'd12;
        end else if (cur_slot >= 5'd6) begin
            grp    = OP_S3;
            ch_off = cur_slot - 5'd6;
        end
    end

    always_comb begin
        carrier = 1'b0;
        case (grp)
            OP_S1:   carrier = (alg == 3'd7);
            OP_S3:   carrier = (alg >= 3'd5);
            OP_S2:   carrier = (alg >= 3'd4);
            default: carrier = 1'b1;
        endcase
    end

    always_comb begin
        sat = sum[8:0];
        if (sum > 12'sd255) begin
            sat = 9'h0ff;
        end else if (sum < -12'sd256) begin
            sat = 9'h100;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 5'd0;
            synced   <= 1'b0;
            ch_out   <= 9'd0;
            ch_idx   <= 3'd0;
            ch_valid <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                acc[i] <= 12'sd0;
            end
        end else if (clk_en) begin
            cnt      <= (cur_slot == 5'd23) ? 5'd0 : cur_slot + 5'd1;
            ch_valid <= 1'b0;
            if (zero) begin
                synced <= 1'b1;
            end
            if (active) begin
                case (grp)
                    // S1 always overwrites, which also discards partial sums after a resync
                    OP_S1: acc[ch] <= carrier ? op_ext : 12'sd0;
                    OP_S3, OP_S2: begin
                        if (carrier) begin
                            acc[ch] <= sum;
                        end
                    end
                    default: begin
                        ch_out   <= mute[ch] ? 9'd0 : sat;
                        ch_idx   <= ch;
                        ch_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
